pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised, flow-controlled pipeline stage register, the successor to the fixed MEM/WB latch. It carries a WIDTH-bit payload with valid/ready handshakes on both sides. A two-entry skid buffer keeps `in_ready_o` free of any combinational path from `out_ready_i`. It also supports a flush that kills in-flight entries and keeps a saturating back-pressure counter. It drops in between any two core stages; the first user is MEM→WB with the packed `mem_wb_payload_t`.

## Interface
- `WIDTH`, default 135: payload width (135 = `$bits(mem_wb_payload_t)`: 64+64+5+1+1).
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush_i` in 1: discard all held entries and any input accepted this cycle.
- `in_valid_i` in 1: upstream payload valid.
- `in_ready_o` out 1: stage can accept a payload.
- `in_data_i` in WIDTH: upstream payload.
- `out_valid_o` out 1: downstream payload valid.
- `out_ready_i` in 1: downstream accepts.
- `out_data_o` out WIDTH: downstream payload (main register).
- `occupancy_o` out 2: entries held, 0..2.
- `stall_cnt_o` out CNT_W: cycles with `out_valid_o && !out_ready_i`, saturating.

## Operation
- Transfers:
  - in_xfer = `in_valid_i && in_ready_o`.
  - out_xfer = `out_valid_o && out_ready_i`.
- State (`pipe_state_e`), driven from the state register only:
  - EMPTY: occ 0, `out_valid_o`=0, `in_ready_o`=1.
  - HALF: occ 1, `out_valid_o`=1, `in_ready_o`=1.
  - FULL: occ 2, `out_valid_o`=1, `in_ready_o`=0.
- EMPTY:
  - in_xfer: main ← in_data, go to HALF.
  - Otherwise: stay.
- HALF:
  - in_xfer only: skid ← in_data, go to FULL.
  - out_xfer only: go to EMPTY.
  - Both: main ← in_data, stay HALF.
  - Neither: stay.
- FULL:
  - out_xfer: main ← skid, go to HALF.
  - Otherwise: hold.
  - No in_xfer is possible in FULL.
- Ordering: payloads leave in strict arrival order; never duplicated, never dropped except by flush.
- flush_i (highest priority after reset):
  - Next state is EMPTY regardless of transfers.
  - A same-cycle out_xfer still counts as delivered.
  - A same-cycle in_xfer is discarded.
  - Payload registers are not cleared; only validity is.
- stall_cnt_o:
  - Increments by 1 each cycle with `out_valid_o && !out_ready_i`.
  - Holds at all-ones once reached.
  - Unaffected by flush; cleared only by reset.
- Reset (`rst_n`=0 at a rising edge, also mid-transfer): state EMPTY, main/skid ← 0, stall_cnt ← 0. After that edge the outputs are:
  - `out_valid_o`=0, `in_ready_o`=1, `occupancy_o`=0.
  - `out_data_o`=0, `stall_cnt_o`=0.
- Reset dominates flush_i and all transfers.

## Timing
- Latency: a payload accepted at edge N is on `out_data_o` with `out_valid_o`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 payload/cycle sustained while `out_ready_i`=1.
- Back-pressure:
  - `out_ready_i` dropping takes effect on `in_ready_o` one cycle later.
  - The skid entry absorbs the one payload already in flight.
- No combinational paths:
  - `in_*` → `out_*` and `out_ready_i` → `in_ready_o` are both forbidden.
  - All outputs come directly from flops or from decodes of the state register.
- Recovery: after FULL → HALF on out_xfer, `in_ready_o`=1 in the very next cycle.

## Structure
- Shared `pipe_pkg` holds:
  - `pipe_state_e` {EMPTY, HALF, FULL}.
  - `mem_wb_payload_t` packed struct {alu_result[63:0], mem_data[63:0], rd_addr[4:0], reg_write, mem_to_reg}.
  - `MEM_WB_W` localparam = `$bits(mem_wb_payload_t)`.
- One sub-module, `sat_counter` (parameter CNT_W; ports: inc, synchronous clear, count), instantiated for `stall_cnt_o`.
- Main and skid registers plus the FSM stay in `pipe_skid_stage`.

## Test plan
- Reset: drive `rst_n`=0 for 2 edges with `in_valid_i`=1 and data 0x5A → `out_valid_o`=0, `in_ready_o`=1, `occupancy_o`=0, `stall_cnt_o`=0.
- Streaming: `out_ready_i`=1, send 0x1, 0x2, 0x3 on consecutive cycles → the same values appear one cycle later on consecutive cycles; `occupancy_o` stays 1.
- Skid: hold `out_ready_i`=0, send 0xA then 0xB:
  - `occupancy_o` becomes 2 and `in_ready_o`=0.
  - Release `out_ready_i` → 0xA then 0xB, in order.
  - `stall_cnt_o` equals the count of stalled valid cycles.
- Flush in FULL with `in_valid_i`=1 → next cycle `out_valid_o`=0, `occupancy_o`=0; neither held payload nor the input appears later.
- Simultaneous in/out in HALF: holding 0x7, push 0x8 with `out_ready_i`=1 → 0x7 consumed, 0x8 on `out_data_o` next cycle, occ stays 1.
- Saturation: CNT_W=4, stall for 20 cycles → `stall_cnt_o`=0xF and holds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for flow-controlled pipeline stages: stage FSM encoding and
// the MEM->WB payload layout carried by the first user of pipe_skid_stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [63:0] alu_result;
    logic [63:0] mem_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_to_reg;
  } mem_wb_payload_t;

  localparam int MEM_WB_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream and downstream valid/ready/data handshake of one pipe_skid_stage.
// The stage uses the slave modport; the surrounding pipeline uses master.
interface pipe_skid_stage_if #(
  parameter int WIDTH = pipe_pkg::MEM_WB_W
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

endinterface

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples its inputs as they were before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Flow-controlled pipeline register with a two-entry skid buffer, flush and a
// saturating back-pressure counter. in_ready_o depends on the state only.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = MEM_WB_W,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  pipe_skid_stage_if.slave      bus,
  output logic [1:0]            occupancy_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;
  logic             in_xfer, out_xfer;

  assign in_xfer  = bus.in_valid_i  && bus.in_ready_o;
  assign out_xfer = bus.out_valid_o && bus.out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: if (in_xfer) begin
        load_main_in = 1'b1;
        state_d      = HALF;
      end
      HALF: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: if (out_xfer) begin
        load_main_skid = 1'b1;
        state_d        = HALF;
      end
      default: state_d = EMPTY;
    endcase
    // Flush kills validity only; payload registers keep their last contents.
    if (flush_i) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_comb begin
    bus.out_valid_o = 1'b0;
    bus.in_ready_o  = 1'b1;
    occupancy_o     = 2'd0;
    unique case (state_q)
      EMPTY: ;
      HALF: begin
        bus.out_valid_o = 1'b1;
        occupancy_o     = 2'd1;
      end
      FULL: begin
        bus.out_valid_o = 1'b1;
        bus.in_ready_o  = 1'b0;
        occupancy_o     = 2'd2;
      end
      default: ;
    endcase
  end

  // NOTE: the payload registers are reset so out_data_o reads zero after reset;
  // the rest of the time they are qualified only by the FSM's validity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= bus.in_data_i;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= bus.in_data_i;
    end
  end

  assign bus.out_data_o = main_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (bus.out_valid_o && !bus.out_ready_i),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, skid, flush,
// simultaneous in/out, and stall-counter saturation on a CNT_W=4 instance.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int WA = MEM_WB_W;
  localparam int WB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_a, flush_b;
  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.WIDTH(WA)) bus_a ();
  pipe_skid_stage_if #(.WIDTH(WB)) bus_b ();

  pipe_skid_stage #(.WIDTH(WA), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_a), .bus(bus_a),
    .occupancy_o(occ_a), .stall_cnt_o(stall_a)
  );

  pipe_skid_stage #(.WIDTH(WB), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_b), .bus(bus_b),
    .occupancy_o(occ_b), .stall_cnt_o(stall_b)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0;
    bus_a.in_valid_i = 1'b1; bus_a.in_data_i = WA'(8'h5A); bus_a.out_ready_i = 1'b0;
    bus_b.in_valid_i = 1'b1; bus_b.in_data_i = WB'(8'h5A); bus_b.out_ready_i = 1'b0;
    tick(2);
    check("rst_out_valid", bus_a.out_valid_o, 0);
    check("rst_in_ready",  bus_a.in_ready_o,  1);
    check("rst_occ",       occ_a,             0);
    check("rst_stall",     stall_a,           0);
    check("rst_data",      bus_a.out_data_o,  0);
    check("rst_b_occ",     occ_b,             0);

    rst_n = 1'b1;
    bus_a.in_valid_i = 1'b0; bus_a.out_ready_i = 1'b1;
    bus_b.in_valid_i = 1'b0; bus_b.out_ready_i = 1'b1;
    tick();

    // Streaming 1,2,3 with the sink always ready.
    bus_a.in_valid_i = 1'b1; bus_a.in_data_i = WA'(1);
    tick();
    check("strm_d1", bus_a.out_data_o, 1);
    check("strm_v1", bus_a.out_valid_o, 1);
    check("strm_o1", occ_a, 1);
    bus_a.in_data_i = WA'(2);
    tick();
    check("strm_d2", bus_a.out_data_o, 2);
    check("strm_o2", occ_a, 1);
    bus_a.in_data_i = WA'(3);
    tick();
    check("strm_d3", bus_a.out_data_o, 3);
    check("strm_o3", occ_a, 1);
    bus_a.in_valid_i = 1'b0;
    tick();
    check("strm_drain_occ", occ_a, 0);
    check("strm_drain_v", bus_a.out_valid_o, 0);
    check("strm_stall", stall_a, 0);

    // Skid: sink stalled, push 0xA then 0xB.
    bus_a.out_ready_i = 1'b0;
    bus_a.in_valid_i = 1'b1; bus_a.in_data_i = WA'(8'hA);
    tick();
    check("skid_occ1", occ_a, 1);
    check("skid_rdy1", bus_a.in_ready_o, 1);
    bus_a.in_data_i = WA'(8'hB);
    tick();
    check("skid_occ2", occ_a, 2);
    check("skid_rdy0", bus_a.in_ready_o, 0);
    check("skid_head", bus_a.out_data_o, 8'hA);
    bus_a.in_valid_i = 1'b0;
    tick();
    check("skid_hold_occ", occ_a, 2);
    check("skid_stall2", stall_a, 2);
    bus_a.out_ready_i = 1'b1;
    #1;
    check("skid_out_a", bus_a.out_data_o, 8'hA);
    tick();
    check("skid_out_b", bus_a.out_data_o, 8'hB);
    check("skid_occ_after", occ_a, 1);
    check("skid_recover_rdy", bus_a.in_ready_o, 1);
    tick();
    check("skid_empty", occ_a, 0);
    check("skid_stall_final", stall_a, 2);

    // Flush in FULL with input valid.
    bus_a.out_ready_i = 1'b0;
    bus_a.in_valid_i = 1'b1; bus_a.in_data_i = WA'(8'hC1);
    tick();
    bus_a.in_data_i = WA'(8'hC2);
    tick();
    check("fl_full", occ_a, 2);
    flush_a = 1'b1; bus_a.in_data_i = WA'(8'hC3);
    tick();
    check("fl_valid", bus_a.out_valid_o, 0);
    check("fl_occ", occ_a, 0);
    check("fl_rdy", bus_a.in_ready_o, 1);
    flush_a = 1'b0; bus_a.in_valid_i = 1'b0; bus_a.out_ready_i = 1'b1;
    tick();
    check("fl_no_ghost", bus_a.out_valid_o, 0);
    check("fl_stall", stall_a, 4);

    // Flush in HALF discards the same-cycle input.
    bus_a.out_ready_i = 1'b0;
    bus_a.in_valid_i = 1'b1; bus_a.in_data_i = WA'(8'hD1);
    tick();
    flush_a = 1'b1; bus_a.in_data_i = WA'(8'hD2);
    tick();
    flush_a = 1'b0; bus_a.in_valid_i = 1'b0;
    tick();
    check("flh_occ", occ_a, 0);
    check("flh_valid", bus_a.out_valid_o, 0);
    check("flh_stall", stall_a, 5);

    // Simultaneous in/out while HALF.
    bus_a.in_valid_i = 1'b1; bus_a.in_data_i = WA'(7);
    tick();
    bus_a.out_ready_i = 1'b1; bus_a.in_data_i = WA'(8);
    #1;
    check("sim_head7", bus_a.out_data_o, 7);
    tick();
    check("sim_d8", bus_a.out_data_o, 8);
    check("sim_occ", occ_a, 1);
    bus_a.in_valid_i = 1'b0;
    tick();
    check("sim_empty", occ_a, 0);
    check("sim_stall", stall_a, 5);

    // Saturation on the CNT_W=4 instance.
    bus_b.out_ready_i = 1'b0;
    bus_b.in_valid_i = 1'b1; bus_b.in_data_i = WB'(8'h33);
    tick();
    bus_b.in_valid_i = 1'b0;
    tick(14);
    check("sat_14", stall_b, 4'hE);
    tick();
    check("sat_15", stall_b, 4'hF);
    tick(5);
    check("sat_hold", stall_b, 4'hF);
    check("sat_data", bus_b.out_data_o, 8'h33);
    check("sat_occ", occ_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
